// File: rtl/security_hazard_monitor.sv
// security_hazard_monitor
//   Counts rising edges of per-channel threat inputs over fixed observation
//   windows and classifies each window into a 2-bit security level. Levels can
//   drop by at most one step per window (DECAY_EN=1), and also decay by one
//   step per quiet window while idle.
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   threat     in   [NUM_CH]   per-channel threat indication
//   clear      in   synchronous clear of all channel state
//   ch_level   out  [2*NUM_CH] registered level, channel i at [2i+1:2i]
//   level_up   out  [NUM_CH]   one-cycle pulse when a channel level rises
//   max_level  out  [2]        registered max of all ch_level fields

// One threat channel: edge detect, IDLE/WINDOW FSM, window timer, event
// counter and level register.
module shm_channel #(
    parameter int WINDOW_CYCLES = 100_000_000,
    parameter int CNT_WIDTH     = 8,
    parameter int THR1          = 3,
    parameter int THR2          = 7,
    parameter int THR3          = 11,
    parameter int DECAY_EN      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       threat,
    input  logic       clear,
    output logic [1:0] level,
    output logic       level_up
);
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam logic [TW-1:0]        T_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] C_T1   = CNT_WIDTH'(THR1);
    localparam logic [CNT_WIDTH-1:0] C_T2   = CNT_WIDTH'(THR2);
    localparam logic [CNT_WIDTH-1:0] C_T3   = CNT_WIDTH'(THR3);

    typedef enum logic {IDLE = 1'b0, WINDOW = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_close;
    logic [1:0]           level_nxt, cls, close_level;
    logic                 up_nxt, prev, rise, at_last;

    assign rise    = threat & ~prev;
    assign at_last = (timer == T_LAST);

    // Count including this cycle's edge, so an edge on the closing cycle
    // still lands in the closing window. Saturates instead of wrapping.
    assign cnt_close = (rise && cnt != C_MAX) ? cnt + CNT_WIDTH'(1) : cnt;

    always_comb begin
        if (cnt_close < C_T1)      cls = 2'd0;
        else if (cnt_close < C_T2) cls = 2'd1;
        else if (cnt_close < C_T3) cls = 2'd2;
        else                       cls = 2'd3;
    end

    // A lower classification only pulls the level down one step when decay
    // is enabled; cls < level implies level >= 1, so no underflow.
    assign close_level = (cls >= level) ? cls :
                         ((DECAY_EN != 0) ? level - 2'd1 : cls);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            cnt      <= '0;
            level    <= 2'd0;
            level_up <= 1'b0;
            prev     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            level_up <= up_nxt;
            prev     <= threat;   // history keeps tracking even under clear
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        if (clear)                         state_nxt = IDLE;
        else if (state == IDLE && rise)    state_nxt = WINDOW;
        else if (state == WINDOW && at_last) state_nxt = IDLE;
    end

    // Datapath / outputs
    always_comb begin
        timer_nxt = timer;
        cnt_nxt   = cnt;
        level_nxt = level;
        up_nxt    = 1'b0;
        if (clear) begin
            timer_nxt = '0;
            cnt_nxt   = '0;
            level_nxt = 2'd0;
        end else if (state == IDLE) begin
            if (rise) begin
                timer_nxt = '0;
                cnt_nxt   = CNT_WIDTH'(1);
            end else if (DECAY_EN != 0 && level != 2'd0) begin
                // Quiet-window decay: one step per WINDOW_CYCLES edge-free cycles
                if (at_last) begin
                    timer_nxt = '0;
                    level_nxt = level - 2'd1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end else begin
                timer_nxt = '0;
            end
        end else begin
            if (at_last) begin
                timer_nxt = '0;
                cnt_nxt   = '0;
                level_nxt = close_level;
                up_nxt    = (close_level > level);
            end else begin
                timer_nxt = timer + TW'(1);
                cnt_nxt   = cnt_close;
            end
        end
    end
endmodule

module security_hazard_monitor #(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = 100_000_000,
    parameter int CNT_WIDTH     = 8,
    parameter int THR1          = 3,
    parameter int THR2          = 7,
    parameter int THR3          = 11,
    parameter int DECAY_EN      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   threat,
    input  logic                clear,
    output logic [2*NUM_CH-1:0] ch_level,
    output logic [NUM_CH-1:0]   level_up,
    output logic [1:0]          max_level
);
    logic [1:0] lvl_max;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        shm_channel #(
            .WINDOW_CYCLES(WINDOW_CYCLES),
            .CNT_WIDTH    (CNT_WIDTH),
            .THR1         (THR1),
            .THR2         (THR2),
            .THR3         (THR3),
            .DECAY_EN     (DECAY_EN)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .threat  (threat[i]),
            .clear   (clear),
            .level   (ch_level[2*i +: 2]),
            .level_up(level_up[i])
        );
    end

    always_comb begin
        lvl_max = 2'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_level[2*i +: 2] > lvl_max) lvl_max = ch_level[2*i +: 2];
    end

    // Registered from the already-registered levels: follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     max_level <= 2'd0;
        else if (clear) max_level <= 2'd0;
        else            max_level <= lvl_max;
    end
endmodule

// File: tb/tb_security_hazard_monitor.sv
// Testbench for security_hazard_monitor. Three instances share clock, reset
// and clear: A (16-cycle window, decay on), B (16-cycle window, decay off),
// C (1024-cycle window, decay on, room for many events per window).
// Expected output snapshots {ch_level, level_up, max_level} are queued with
// the cycle they are due and compared when that cycle is reached.
module tb_security_hazard_monitor;
    localparam int A = 0, B = 1, C = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] th_a = 2'b00, th_b = 2'b00, th_c = 2'b00;
    logic [3:0] lvl_a, lvl_b, lvl_c;
    logic [1:0] up_a, up_b, up_c, mx_a, mx_b, mx_c;
    int         cyc = 0;
    int         total = 0, bad = 0;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;
    exp_t sb[$];

    security_hazard_monitor #(.NUM_CH(2), .WINDOW_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .threat(th_a), .clear(clear),
        .ch_level(lvl_a), .level_up(up_a), .max_level(mx_a));
    security_hazard_monitor #(.NUM_CH(2), .WINDOW_CYCLES(16), .DECAY_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .threat(th_b), .clear(clear),
        .ch_level(lvl_b), .level_up(up_b), .max_level(mx_b));
    security_hazard_monitor #(.NUM_CH(2), .WINDOW_CYCLES(1024)) dut_c (
        .clk(clk), .rst_n(rst_n), .threat(th_c), .clear(clear),
        .ch_level(lvl_c), .level_up(up_c), .max_level(mx_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] obs(int s);
        case (s)
            A:       return {lvl_a, up_a, mx_a};
            B:       return {lvl_b, up_b, mx_b};
            default: return {lvl_c, up_c, mx_c};
        endcase
    endfunction

    function automatic logic [7:0] v(logic [3:0] l, logic [1:0] u, logic [1:0] m);
        return {l, u, m};
    endfunction

    task automatic push(int c, int s, logic [7:0] val, string n);
        exp_t e;
        e.cyc = c; e.sel = s; e.val = val; e.name = n;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        th_a = 2'b00; th_b = 2'b00; th_c = 2'b00; clear = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e; int c0;
        @(negedge clk); rst_n = 1'b0; c0 = cyc;
        for (int k = 1; k <= 10; k++)
            for (int s = 0; s < 3; s++) push(c0 + k, s, 8'h00, "reset_hold");
        for (int k = 11; k <= 30; k++)
            for (int s = 0; s < 3; s++) push(c0 + k, s, 8'h00, "post_release");
        for (int k = 0; k < 30; k++) begin
            th_a = (k < 10 && k % 2 == 0) ? 2'b11 : 2'b00;
            th_b = th_a; th_c = th_a;
            if (k == 10) rst_n = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    // Threat already high when reset releases counts as the first edge.
    task automatic test_first_cycle_edge();
        exp_t e; int c0;
        th_a = 2'b01; th_b = 2'b00; th_c = 2'b00;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; c0 = cyc;
        push(c0 + 16, A, 8'h00, "first_edge_pre");
        push(c0 + 17, A, v(4'h1, 2'b01, 2'd0), "first_edge_close");
        push(c0 + 18, A, v(4'h1, 2'b00, 2'd1), "first_edge_max");
        for (int k = 0; k < 20; k++) begin
            th_a = (k == 0 || k == 2 || k == 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_level1();
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        for (int k = 1; k <= 16; k++) push(c0 + k, A, 8'h00, "l1_open");
        push(c0 + 17, A, v(4'h1, 2'b01, 2'd0), "l1_close");
        for (int k = 18; k <= 32; k++) push(c0 + k, A, v(4'h1, 2'b00, 2'd1), "l1_hold");
        push(c0 + 33, A, v(4'h0, 2'b00, 2'd1), "l1_decay");
        push(c0 + 34, A, 8'h00, "l1_decay_max");
        for (int k = 0; k < 36; k++) begin
            th_a = (k == 0 || k == 2 || k == 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
        do_reset(); c0 = cyc;
        for (int k = 1; k <= 20; k++) push(c0 + k, A, 8'h00, "two_pulses_stay0");
        for (int k = 0; k < 22; k++) begin
            th_a = (k == 0 || k == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_two_channels();
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        push(c0 + 30,   C, 8'h00, "two_ch_open");
        push(c0 + 1024, C, 8'h00, "two_ch_pre");
        push(c0 + 1025, C, v(4'b1011, 2'b11, 2'd0), "two_ch_close");
        push(c0 + 1026, C, v(4'b1011, 2'b00, 2'd3), "two_ch_max");
        for (int k = 0; k < 1028; k++) begin
            th_c = {1'(k < 14 && k % 2 == 0), 1'(k < 24 && k % 2 == 0)};
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    // A: level 2 decays 2->1->0 every 16 cycles. B (no decay): level 2 holds
    // while idle, then a 1-event window drops it straight to 0. C: 3->2->1->0.
    task automatic test_decay();
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        push(c0 + 16, A, 8'h00, "decay_a_pre");
        push(c0 + 17, A, v(4'h2, 2'b01, 2'd0), "decay_a_close");
        push(c0 + 17, B, v(4'h2, 2'b01, 2'd0), "nodecay_close");
        push(c0 + 18, A, v(4'h2, 2'b00, 2'd2), "decay_a_max");
        push(c0 + 18, B, v(4'h2, 2'b00, 2'd2), "nodecay_max");
        push(c0 + 32, A, v(4'h2, 2'b00, 2'd2), "decay_a_hold2");
        push(c0 + 33, A, v(4'h1, 2'b00, 2'd2), "decay_a_to1");
        push(c0 + 34, A, v(4'h1, 2'b00, 2'd1), "decay_a_to1_max");
        push(c0 + 40, B, v(4'h2, 2'b00, 2'd2), "nodecay_idle_hold");
        push(c0 + 48, A, v(4'h1, 2'b00, 2'd1), "decay_a_hold1");
        push(c0 + 49, A, v(4'h0, 2'b00, 2'd1), "decay_a_to0");
        push(c0 + 50, A, 8'h00, "decay_a_to0_max");
        push(c0 + 56, B, v(4'h2, 2'b00, 2'd2), "nodecay_pre");
        push(c0 + 57, B, v(4'h0, 2'b00, 2'd2), "nodecay_drop");
        push(c0 + 58, B, 8'h00, "nodecay_drop_max");
        push(c0 + 1024, C, 8'h00, "decay_c_pre");
        push(c0 + 1025, C, v(4'h3, 2'b01, 2'd0), "decay_c_close");
        push(c0 + 1026, C, v(4'h3, 2'b00, 2'd3), "decay_c_max");
        push(c0 + 2048, C, v(4'h3, 2'b00, 2'd3), "decay_c_hold3");
        push(c0 + 2049, C, v(4'h2, 2'b00, 2'd3), "decay_c_to2");
        push(c0 + 2050, C, v(4'h2, 2'b00, 2'd2), "decay_c_to2_max");
        push(c0 + 3072, C, v(4'h2, 2'b00, 2'd2), "decay_c_hold2");
        push(c0 + 3073, C, v(4'h1, 2'b00, 2'd2), "decay_c_to1");
        push(c0 + 3074, C, v(4'h1, 2'b00, 2'd1), "decay_c_to1_max");
        push(c0 + 4096, C, v(4'h1, 2'b00, 2'd1), "decay_c_hold1");
        push(c0 + 4097, C, v(4'h0, 2'b00, 2'd1), "decay_c_to0");
        push(c0 + 4098, C, 8'h00, "decay_c_to0_max");
        for (int k = 0; k < 4100; k++) begin
            th_a = {1'b0, 1'(k < 14 && k % 2 == 0)};
            th_b = {1'b0, 1'((k < 14 && k % 2 == 0) || k == 40)};
            th_c = {1'b0, 1'(k < 24 && k % 2 == 0)};
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        push(c0 + 16, A, 8'h00, "hold_pre");
        push(c0 + 17, A, 8'h00, "hold_close");
        push(c0 + 18, A, 8'h00, "hold_after");
        push(c0 + 41, A, 8'h00, "hold_end");
        for (int k = 0; k < 43; k++) begin
            th_a = {1'b0, 1'(k < 40)};
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    // ch0: 300 edges, ch1: 257 edges; both must saturate at 255 (a wrapping
    // counter would leave ch1 at 1 -> level 0).
    task automatic test_saturate();
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        push(c0 + 1024, C, 8'h00, "sat_pre");
        push(c0 + 1025, C, v(4'hF, 2'b11, 2'd0), "sat_close");
        push(c0 + 1026, C, v(4'hF, 2'b00, 2'd3), "sat_max");
        for (int k = 0; k < 1028; k++) begin
            th_c = {1'(k < 514 && k % 2 == 0), 1'(k < 600 && k % 2 == 0)};
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
    endtask

    // use_reset=0: clear pulse mid-window; 1: rst_n pulse mid-window.
    task automatic test_clear(int use_reset);
        exp_t e; int c0;
        do_reset(); c0 = cyc;
        push(c0 + 30,   A, v(4'h1, 2'b00, 2'd1), "clr_a_before");
        push(c0 + 31,   A, 8'h00, "clr_a_after");
        push(c0 + 31,   C, 8'h00, "clr_c_after");
        push(c0 + 1024, C, 8'h00, "clr_c_pre_close");
        push(c0 + 1025, C, 8'h00, "clr_c_no_close");
        push(c0 + 1026, C, 8'h00, "clr_c_no_max");
        for (int k = 0; k < 1028; k++) begin
            th_a = (k == 0 || k == 2 || k == 4) ? 2'b01 : 2'b00;
            th_c = {1'b0, 1'((k < 20 && k % 2 == 0) || (use_reset == 0 && k == 30))};
            if (use_reset != 0) rst_n = !(k == 30 || k == 31);
            else                clear = (k == 30);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); total++;
                if (obs(e.sel) !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d dut=%0d got=%h want=%h", e.name, cyc, e.sel, obs(e.sel), e.val);
                end
            end
        end
        rst_n = 1'b1; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_cycle_edge();
        test_level1();
        test_two_channels();
        test_decay();
        test_hold();
        test_saturate();
        test_clear(0);
        test_clear(1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
